spi_txn_scheduler: RTL and testbench

//  Shares one SPI byte engine among NUM_REQ requesters inside tt_um_spi_aggregator.

---
 rtl/spi_agg_pkg.sv | 24 ++
 rtl/spi_rr_arbiter.sv | 38 +++
 rtl/spi_txn_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_agg_pkg.sv
// Shared definitions for the SPI transaction scheduler slice.
//   BYTE_W   : width of one SPI byte
//   ERR_BYTE : response byte reported when the watchdog aborts a transfer
//   state_t  : scheduler FSM states
//   id_w()   : width of a requester index for a given requester count
package spi_agg_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick.
//   req       : request vector
//   ptr       : index with highest priority this round
//   winner    : one-hot winner (all zero when no request)
//   winner_id : index of the winner
//   found     : at least one request present
// Scan order is ptr, ptr+1, ... wrapping from NUM_REQ-1 to 0.
module spi_rr_arbiter
  import spi_agg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    winner_id,
  output logic               found
);

  logic [ID_W-1:0] idx;

  always_comb begin
    winner    = '0;
    winner_id = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_id   = idx;
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI byte engine among NUM_REQ requesters.
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   req         : level request per requester
//   req_data    : TX byte per requester, requester i at [8i+7:8i]
//   grant       : one-cycle one-hot pulse; TX byte captured on that edge
//   resp_valid  : one-cycle pulse qualifying resp_id/resp_data/resp_err
//   resp_id     : requester owning the response
//   resp_data   : received byte, ERR_BYTE on watchdog timeout
//   resp_err    : 1 when the watchdog aborted the transfer
//   cs_n        : active-low chip selects, at most one low
//   eng_start   : one-cycle start pulse to the byte engine
//   eng_tx      : TX byte, held from eng_start until the response
//   eng_busy    : engine busy; blocks arbitration
//   eng_done    : engine done pulse, honoured only while transferring
//   eng_rx      : RX byte, valid with eng_done
//   idle        : 1 while the scheduler is idle
// All outputs are registered.
module spi_txn_scheduler
  import spi_agg_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [7:0]                 resp_data,
  output logic                       resp_err,
  output logic [NUM_REQ-1:0]         cs_n,
  output logic                       eng_start,
  output logic [7:0]                 eng_tx,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic [7:0]                 eng_rx,
  output logic                       idle
);

  localparam int ID_W    = id_w(NUM_REQ);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                           ? ((CS_SETUP > GAP) ? CS_SETUP : GAP)
                           : ((CS_HOLD > GAP) ? CS_HOLD : GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   cs_n_q, cs_n_d;
  logic                 eng_start_q, eng_start_d;
  logic [BYTE_W-1:0]    eng_tx_q, eng_tx_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [BYTE_W-1:0]    resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic                 idle_q, idle_d;

  logic [NUM_REQ-1:0]   win_oh;
  logic [ID_W-1:0]      win_id;
  logic                 win_found;
  logic [ID_W-1:0]      next_ptr;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .winner    (win_oh),
    .winner_id (win_id),
    .found     (win_found)
  );

  assign next_ptr = ID_W'((32'(id_q) + 1) % NUM_REQ);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    grant_d      = '0;
    cs_n_d       = cs_n_q;
    eng_start_d  = 1'b0;
    eng_tx_d     = eng_tx_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    idle_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        idle_d = 1'b1;
        if (win_found && !eng_busy) begin
          grant_d  = win_oh;
          cs_n_d   = ~win_oh;
          eng_tx_d = req_data[int'(win_id)*BYTE_W +: BYTE_W];
          id_d     = win_id;
          cnt_d    = '0;
          idle_d   = 1'b0;
          state_d  = ST_SETUP;
        end
      end

      // eng_start is registered on the edge that leaves SETUP, so it rises
      // exactly CS_SETUP edges after cs_n fell.
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          eng_start_d = 1'b1;
          state_d     = ST_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // wd counts edges since eng_start rose; the edge leaving START is the first.
      ST_START: begin
        wd_d    = WD_W'(1);
        state_d = ST_XFER;
      end

      // eng_done wins over an expiring watchdog on the same edge.
      ST_XFER: begin
        if (eng_done) begin
          resp_valid_d = 1'b1;
          resp_data_d  = eng_rx;
          resp_err_d   = 1'b0;
          cnt_d        = '0;
          state_d      = ST_HOLD;
        end else if (wd_q >= WD_W'(TIMEOUT - 1)) begin
          resp_valid_d = 1'b1;
          resp_data_d  = ERR_BYTE;
          resp_err_d   = 1'b1;
          cnt_d        = '0;
          state_d      = ST_HOLD;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cs_n_d = '1;
          cnt_d  = '0;
          if (GAP == 0) begin
            ptr_d   = next_ptr;
            idle_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          ptr_d   = next_ptr;
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cs_n_d  = '1;
        idle_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wd_q         <= '0;
      ptr_q        <= '0;
      id_q         <= '0;
      grant_q      <= '0;
      cs_n_q       <= '1;
      eng_start_q  <= 1'b0;
      eng_tx_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      grant_q      <= grant_d;
      cs_n_q       <= cs_n_d;
      eng_start_q  <= eng_start_d;
      eng_tx_q     <= eng_tx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      idle_q       <= idle_d;
    end
  end

  assign grant      = grant_q;
  assign cs_n       = cs_n_q;
  assign eng_start  = eng_start_q;
  assign eng_tx     = eng_tx_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
module tb_spi_txn_scheduler;

  localparam int N     = 4;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAPC  = 1;
  localparam int TO    = 16;
  localparam int ID_W  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    grant;
  logic            resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [7:0]      resp_data;
  logic            resp_err;
  logic [N-1:0]    cs_n;
  logic            eng_start;
  logic [7:0]      eng_tx;
  logic            eng_busy;
  logic            eng_done;
  logic [7:0]      eng_rx;
  logic            idle;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mptr   = 0;
  bit   mon_en = 1'b0;

  // engine model controls
  int         eng_delay  = 4;
  bit         eng_enable = 1'b1;
  logic [7:0] eng_rx_val = 8'h00;

  spi_txn_scheduler #(
    .NUM_REQ  (N),
    .CS_SETUP (SETUP),
    .CS_HOLD  (HOLD),
    .GAP      (GAPC),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .cs_n       (cs_n),
    .eng_start  (eng_start),
    .eng_tx     (eng_tx),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .eng_rx     (eng_rx),
    .idle       (idle)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: simulation did not finish, want finish");
    $fatal(1, "time limit");
  end

  // Byte engine: sees eng_start, raises eng_done eng_delay cycles later.
  // The scheduler therefore sees done eng_delay+1 edges after eng_start rose.
  initial begin : engine_model
    int cnt;
    bit pend;
    pend = 1'b0; cnt = 0; eng_done = 1'b0; eng_rx = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_rx   = eng_rx_val;
          pend     = 1'b0;
        end else cnt--;
      end else if (eng_start === 1'b1 && eng_enable) begin
        pend = 1'b1;
        cnt  = eng_delay - 1;
      end
    end
  end

  // Continuous safety: never two chip selects low, never two grants.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      checks++;
      if ($countones(~cs_n) > 1 || $countones(grant) > 1) begin
        errors++;
        $display("FAIL onehot: cs_n=%b grant=%b want at most one active each", cs_n, grant);
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One full transaction, observed from grant to return to IDLE.
  task automatic expect_txn(input int id, input logic [7:0] tx, input logic [7:0] rx,
                            input bit err, input int lat, input int pre_g, input string tag);
    logic [N-1:0] oh;
    int g, s, r, n;
    oh = '0;
    oh[id] = 1'b1;
    if (pre_g < 0) begin
      n = 0;
      while (grant === '0 && n < 200) begin @(negedge clk); n++; end
      g = cyc;
      checks++;
      if (grant !== oh || cs_n !== ~oh || idle !== 1'b0) begin
        errors++;
        $display("FAIL %s_grant: grant=%b cs_n=%b idle=%b want grant=%b cs_n=%b idle=0",
                 tag, grant, cs_n, idle, oh, ~oh);
      end
      if (grant === '0) return;
    end else g = pre_g;
    @(negedge clk);
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL %s_grant_pulse: grant=%b want 0", tag, grant);
    end
    n = 0;
    while (eng_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    s = cyc;
    checks++;
    if (eng_start !== 1'b1 || s - g != SETUP || eng_tx !== tx || cs_n !== ~oh) begin
      errors++;
      $display("FAIL %s_start: start=%b dly=%0d tx=%h cs_n=%b want start=1 dly=%0d tx=%h cs_n=%b",
               tag, eng_start, s - g, eng_tx, cs_n, SETUP, tx, ~oh);
    end
    if (eng_start !== 1'b1) return;
    n = 0;
    while (resp_valid !== 1'b1 && n < TO + 40) begin @(negedge clk); n++; end
    r = cyc;
    checks++;
    if (resp_valid !== 1'b1 || r - s != lat) begin
      errors++;
      $display("FAIL %s_latency: valid=%b lat=%0d want valid=1 lat=%0d", tag, resp_valid, r - s, lat);
    end
    checks++;
    if (resp_id !== ID_W'(id) || resp_data !== rx || resp_err !== err || eng_tx !== tx || cs_n !== ~oh) begin
      errors++;
      $display("FAIL %s_resp: id=%0d data=%h err=%b tx=%h cs_n=%b want id=%0d data=%h err=%b tx=%h cs_n=%b",
               tag, resp_id, resp_data, resp_err, eng_tx, cs_n, id, rx, err, tx, ~oh);
    end
    if (resp_valid !== 1'b1) return;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_pulse: resp_valid=%b want 0", tag, resp_valid);
    end
    n = 0;
    while (cs_n !== '1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cs_n !== '1 || cyc - r != HOLD) begin
      errors++;
      $display("FAIL %s_release: cs_n=%b hold=%0d want cs_n=1111 hold=%0d", tag, cs_n, cyc - r, HOLD);
    end
    repeat (GAPC) @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: idle=%b want 1", tag, idle);
    end
    mptr = (id + 1) % N;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; req_data = '0; eng_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, eng_start, resp_valid, resp_err} !== '0) begin
      errors++;
      $display("FAIL reset_pulses: grant=%b start=%b valid=%b err=%b want all 0",
               grant, eng_start, resp_valid, resp_err);
    end
    checks++;
    if (cs_n !== '1) begin errors++; $display("FAIL reset_cs_n: cs_n=%b want 1111", cs_n); end
    checks++;
    if (resp_id !== '0 || resp_data !== 8'h00 || eng_tx !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: id=%0d data=%h tx=%h want 0 00 00", resp_id, resp_data, eng_tx);
    end
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: idle=%b want 1", idle); end
    rst = 1'b0; mon_en = 1'b1; mptr = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (idle !== 1'b1 || grant !== '0) begin
      errors++;
      $display("FAIL reset_quiet: idle=%b grant=%b want 1 0000", idle, grant);
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    req_data = $urandom;
    req = '1;
    for (int t = 0; t < 5; t++) begin
      eng_delay  = $urandom_range(2, 6);
      eng_rx_val = 8'($urandom);
      expect_txn(order[t], req_data[8*order[t] +: 8], eng_rx_val, 1'b0, eng_delay + 1, -1, "rr");
    end
    req = '0;
  endtask

  task automatic test_single;
    req_data[23:16] = 8'hA5;
    eng_delay = 8; eng_rx_val = 8'hA5;
    req = 4'b0100;
    expect_txn(2, 8'hA5, 8'hA5, 1'b0, 9, -1, "single");
    req = '0;
  endtask

  task automatic test_wrap;
    req_data = $urandom;
    req = 4'b1001;
    eng_delay = 3; eng_rx_val = 8'h5A;
    expect_txn(3, req_data[31:24], 8'h5A, 1'b0, 4, -1, "wrap3");
    eng_delay = 5; eng_rx_val = 8'hC3;
    expect_txn(0, req_data[7:0], 8'hC3, 1'b0, 6, -1, "wrap0");
    req = '0;
  endtask

  task automatic test_timeout;
    req_data = $urandom;
    eng_enable = 1'b0;
    req = 4'b0100;
    expect_txn(2, req_data[23:16], 8'hFF, 1'b1, TO, -1, "timeout");
    req = '0;
    eng_enable = 1'b1;
    req = 4'b0001;
    eng_delay = TO - 1; eng_rx_val = 8'h3E;
    expect_txn(0, req_data[7:0], 8'h3E, 1'b0, TO, -1, "to_edge_ok");
    eng_delay = TO; eng_rx_val = 8'h77;
    expect_txn(0, req_data[7:0], 8'hFF, 1'b1, TO, -1, "to_edge_late");
    req = '0;
  endtask

  task automatic test_busy;
    bit bad;
    int g;
    req_data = $urandom;
    eng_busy = 1'b1;
    req = 4'b0001;
    bad = 1'b0;
    repeat (6) begin @(negedge clk); if (grant !== '0) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL busy_hold: grant seen while eng_busy=1, want none"); end
    eng_busy = 1'b0;
    @(negedge clk);
    g = cyc;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL busy_release: grant=%b want 0001", grant);
    end
    req = '0; // dropping the request after grant must not abort
    eng_delay = 3; eng_rx_val = 8'h81;
    expect_txn(0, req_data[7:0], 8'h81, 1'b0, 4, g, "busy");
  endtask

  task automatic test_random;
    logic [N-1:0] mask;
    int w, d;
    bit e;
    for (int it = 0; it < 4; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      req_data = $urandom;
      req = mask;
      for (int t = 0; t < 4; t++) begin
        w = rr_pick(mask, mptr);
        d = $urandom_range(1, TO + 3);
        e = (d + 1 > TO);
        eng_delay  = d;
        eng_rx_val = 8'($urandom);
        expect_txn(w, req_data[8*w +: 8], e ? 8'hFF : eng_rx_val, e, e ? TO : d + 1, -1, "rand");
        req_data = $urandom;
      end
      req = '0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    int n;
    req_data = $urandom;
    req = 4'b0010;
    eng_delay = 4; eng_rx_val = 8'h12;
    expect_txn(1, req_data[15:8], 8'h12, 1'b0, 5, -1, "pre_rst");
    req = 4'b0100;
    eng_delay = 10;
    n = 0;
    while (grant === '0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rst_mid_grant: grant=%b want 0100", grant); end
    req = '0;
    n = 0;
    while (eng_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cs_n !== '1 || idle !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: cs_n=%b idle=%b valid=%b want 1111 1 0", cs_n, idle, resp_valid);
    end
    rst = 1'b0;
    mptr = 0;
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || cs_n !== '1 || grant !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_late_done: activity after reset, want none"); end
    req = '1;
    req_data = $urandom;
    eng_delay = 3; eng_rx_val = 8'h9C;
    expect_txn(rr_pick(4'b1111, mptr), req_data[7:0], 8'h9C, 1'b0, 4, -1, "post_rst");
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_timeout();
    test_busy();
    test_random();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
